cbd_sampler: RTL and testbench

- Centered-binomial-distribution sampler (CBD_eta) that sits directly downstream of the SHAKE-256 PRF stage.
- Captures the PRF output string Z when the PRF signals finish (eta1=3 gives 1536 bits; eta2=2 gives 1024 bits).
- Emits the 256 polynomial coefficients, each reduced mod q=3329, one per valid/ready transfer to the polynomial/NTT consumer.
- Signals done after the 256th coefficient is accepted.

---
 rtl/cbd_sampler.sv | 107 ++++++++++
 tb/tb_cbd_sampler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cbd_sampler.sv
// Centered-binomial sampler: captures a PRF output string on a start edge and
// streams 256 CBD_eta coefficients (mod Q) over a valid/ready interface.
module cbd_sampler #(
  parameter int Q      = 3329,
  parameter int N_COEF = 256,
  parameter int COEF_W = 12,
  parameter int Z_W    = 1536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        n_num,
  input  logic [0:Z_W-1]    Z,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [COEF_W-1:0] coef,
  output logic [7:0]        coef_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [0:Z_W-1] sr_q, sr_d;
  logic           eta3_q, eta3_d;
  logic [7:0]     idx_q, idx_d;
  logic           start_prev_q, start_prev_d;

  logic              start_edge;
  logic              n_num_ok;
  logic              xfer;
  logic [1:0]        pop_a, pop_b;
  logic [COEF_W-1:0] coef_dec;

  assign start_edge = start & ~start_prev_q;
  assign n_num_ok   = (n_num == 2'd1) || (n_num == 2'd2);
  assign xfer       = (state_q == BUSY) && coef_ready;

  // Decode from the registered head of the shift register only.
  always_comb begin
    pop_a = 2'd0;
    pop_b = 2'd0;
    if (eta3_q) begin
      pop_a = 2'(sr_q[0]) + 2'(sr_q[1]) + 2'(sr_q[2]);
      pop_b = 2'(sr_q[3]) + 2'(sr_q[4]) + 2'(sr_q[5]);
    end else begin
      pop_a = 2'(sr_q[0]) + 2'(sr_q[1]);
      pop_b = 2'(sr_q[2]) + 2'(sr_q[3]);
    end
    if (pop_a >= pop_b)
      coef_dec = COEF_W'(pop_a - pop_b);
    else
      coef_dec = COEF_W'(Q) - COEF_W'(pop_b - pop_a);
  end

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    eta3_d       = eta3_q;
    idx_d        = idx_q;
    start_prev_d = start;
    case (state_q)
      IDLE, DONE: begin
        if (start_edge && n_num_ok) begin
          sr_d    = Z;
          eta3_d  = (n_num == 2'd1);
          idx_d   = 8'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          sr_d  = eta3_q ? (sr_q << 6) : (sr_q << 4);
          idx_d = idx_q + 8'd1;
          if (idx_q == 8'(N_COEF - 1))
            state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      eta3_q       <= 1'b0;
      idx_q        <= 8'd0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      eta3_q       <= eta3_d;
      idx_q        <= idx_d;
      start_prev_q <= start_prev_d;
    end
  end

  // Outside BUSY the shift register may hold leftover eta=2 bits; mask them.
  assign coef_valid = (state_q == BUSY);
  assign busy       = (state_q == BUSY);
  assign done       = (state_q == DONE);
  assign coef       = (state_q == BUSY) ? coef_dec : '0;
  assign coef_idx   = idx_q;

endmodule

// File: tb/tb_cbd_sampler.sv
// Directed bench for cbd_sampler: golden CBD model feeds a scoreboard queue
// that is drained as the DUT hands over coefficients.
module tb_cbd_sampler;

  localparam int Q   = 3329;
  localparam int Z_W = 1536;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     n_num = 2'd0;
  logic [0:Z_W-1] Z = '0;
  logic           coef_valid;
  logic           coef_ready = 1'b0;
  logic [11:0]    coef;
  logic [7:0]     coef_idx;
  logic           busy;
  logic           done;

  typedef struct {
    int c;
    int i;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  cbd_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_num      (n_num),
    .Z          (Z),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef       (coef),
    .coef_idx   (coef_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int cbd_model(input logic [0:Z_W-1] z, input int eta, input int i);
    int a, b;
    a = 0;
    b = 0;
    for (int k = 0; k < eta; k++) begin
      a += int'(z[2*eta*i + k]);
      b += int'(z[2*eta*i + eta + k]);
    end
    return (a >= b) ? (a - b) : (Q - (b - a));
  endfunction

  // Drive a start edge, queue the expected polynomial, and check load latency.
  task automatic launch(input logic [1:0] n, input bit hold);
    int eta;
    exp_t e;
    eta = (n == 2'd1) ? 3 : 2;
    @(negedge clk);
    n_num = n;
    start = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      e.c = cbd_model(Z, eta, i);
      e.i = i;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (!hold) start = 1'b0;
    check("load_valid", int'(coef_valid), 1);
    check("load_idx", int'(coef_idx), 0);
    check("load_busy", int'(busy), 1);
    check("load_done", int'(done), 0);
  endtask

  // Drain the scoreboard; optional stall window and early stop for reset tests.
  task automatic run_poly(input int stall_at, input int stall_len, input int stop_at);
    int cnt, cyc, stall_left;
    exp_t e;
    cnt = 0;
    cyc = 0;
    stall_left = stall_len;
    while (cnt < 256 && cyc < 2000 && cnt != stop_at) begin
      if (cnt == stall_at && stall_left > 0) begin
        coef_ready = 1'b0;
        stall_left--;
      end else begin
        coef_ready = 1'b1;
      end
      if (coef_valid) begin
        if (coef_ready) begin
          e = exp_q.pop_front();
          check("coef", int'(coef), e.c);
          check("coef_idx", int'(coef_idx), e.i);
          cnt++;
        end else begin
          check("stall_coef", int'(coef), exp_q[0].c);
          check("stall_idx", int'(coef_idx), exp_q[0].i);
        end
      end
      @(negedge clk);
      cyc++;
    end
    coef_ready = 1'b0;
    if (stop_at < 0) begin
      check("xfer_count", cnt, 256);
      check("end_done", int'(done), 1);
      check("end_valid", int'(coef_valid), 0);
      check("end_busy", int'(busy), 0);
      check("end_idx", int'(coef_idx), 0);
    end else begin
      check("stop_count", cnt, stop_at);
    end
  endtask

  initial begin
    rst = 1'b1;
    #1;
    check("rst_valid", int'(coef_valid), 0);
    check("rst_coef", int'(coef), 0);
    check("rst_idx", int'(coef_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    #20;
    rst = 1'b0;

    // Invalid n_num edge in IDLE is ignored.
    @(negedge clk);
    n_num = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_bad_n_busy", int'(busy), 0);
    check("idle_bad_n_valid", int'(coef_valid), 0);

    // eta=3, all zeros.
    Z = '0;
    launch(2'd1, 1'b0);
    run_poly(-1, 0, -1);

    // eta=3, two non-zero coefficients.
    Z = '0;
    Z[0:11] = 12'b111000_000111;
    launch(2'd1, 1'b0);
    check("model_c0_eta3", exp_q[0].c, 3);
    check("model_c1_eta3", exp_q[1].c, 3326);
    run_poly(-1, 0, -1);

    // eta=2, ones elsewhere (including unused upper bits).
    Z = '1;
    Z[0:11] = 12'b1100_0011_1010;
    launch(2'd2, 1'b0);
    run_poly(-1, 0, -1);

    // eta=2 random data with backpressure at index 10.
    for (int i = 0; i < Z_W; i++) Z[i] = 1'($urandom_range(0, 1));
    launch(2'd2, 1'b0);
    run_poly(10, 5, -1);

    // Sticky start: held high through the polynomial must not retrigger.
    for (int i = 0; i < Z_W; i++) Z[i] = 1'($urandom_range(0, 1));
    launch(2'd1, 1'b1);
    run_poly(-1, 0, -1);
    repeat (3) @(negedge clk);
    check("sticky_done", int'(done), 1);
    check("sticky_busy", int'(busy), 0);
    start = 1'b0;
    @(negedge clk);
    n_num = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_bad_n_done", int'(done), 1);
    check("done_bad_n_busy", int'(busy), 0);
    launch(2'd1, 1'b0);

    // Asynchronous reset mid-polynomial at index 100.
    run_poly(-1, 0, 100);
    check("pre_rst_idx", int'(coef_idx), 100);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(coef_valid), 0);
    check("async_rst_idx", int'(coef_idx), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_busy", int'(busy), 0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < Z_W; i++) Z[i] = 1'($urandom_range(0, 1));
    launch(2'd1, 1'b0);
    run_poly(-1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
